// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, data-memory freezes, plus saturating stall/flush counters.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// RUN      (0) | normal issue; load-use and branch events evaluated
// MEM_WAIT (1) | pipeline frozen on dmem_busy; other events held off until exit
// FLUSH_DONE(2)| one cycle after a branch flush; ID/EX and EX/MEM hold bubbles
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             exmem_branch_taken,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_stall,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_MEM_WAIT   = 2'd1;
    localparam logic [1:0] S_FLUSH_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_lu;
    logic             w_evt_ok;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_lu = idex_MemRead && (idex_rd != 5'd0) &&
                  ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    // After a flush, ID/EX and EX/MEM hold bubbles, so neither event is real.
    assign w_evt_ok = (r_state != S_FLUSH_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_RUN;
        case (r_state)
            S_RUN, S_MEM_WAIT: begin
                if (dmem_busy)               w_state_nxt = S_MEM_WAIT;
                else if (exmem_branch_taken) w_state_nxt = S_FLUSH_DONE;
                else                         w_state_nxt = S_RUN;
            end
            S_FLUSH_DONE: begin
                if (dmem_busy) w_state_nxt = S_MEM_WAIT;
                else           w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Priority dmem_busy > branch > load-use; a frozen MEM_WAIT is covered by the
    // dmem_busy term, and its exit cycle behaves exactly like RUN.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_stall  = 1'b0;
        if (dmem_busy) begin
            pipe_stall = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (exmem_branch_taken && w_evt_ok) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_lu && w_evt_ok) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (exmem_flush && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the write-enables and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It also keeps saturating stall and flush event counters for performance analysis.

## Interface
- CNT_W, 32, width of the stall_count and flush_count counters
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- idex_MemRead  in  1  MemRead control currently held in the ID/EX register
- idex_rd  in  5  rd field currently held in the ID/EX register
- ifid_rs1  in  5  rs1 field of the instruction in IF/ID
- ifid_rs2  in  5  rs2 field of the instruction in IF/ID
- exmem_branch_taken  in  1  branch resolved taken in the EX/MEM register
- dmem_busy  in  1  data memory not ready; the pipeline must freeze
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_flush  out  1  zero ID/EX on next edge (Flush input of ID/EX)
- exmem_flush  out  1  zero EX/MEM on next edge
- pipe_stall  out  1  hold ID/EX, EX/MEM and MEM/WB unchanged
- state  out  2  current FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH_DONE
- stall_count  out  CNT_W  cycles with pc_write = 0
- flush_count  out  CNT_W  taken-branch flush events

## Operation
- Load-use hazard is a combinational term:
  - lu = idex_MemRead & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2).
  - rd = x0 never creates a hazard.
- Priority within a cycle: dmem_busy > exmem_branch_taken > lu. Only the highest active event acts.
- **RUN state:**
  - dmem_busy = 1:
    - outputs: pipe_stall = 1, pc_write = 0, ifid_write = 0, no flushes
    - next state: MEM_WAIT
  - else exmem_branch_taken = 1:
    - outputs: ifid_flush = 1, idex_flush = 1, exmem_flush = 1, pc_write = 1 (branch target loads)
    - next state: FLUSH_DONE
    - flush_count increments
  - else lu = 1:
    - outputs: pc_write = 0, ifid_write = 0, idex_flush = 1 (one bubble)
    - next state: RUN (the bubble clears idex_MemRead, so there is no retrigger)
  - else: pc_write = ifid_write = 1, all other outputs 0.
- **MEM_WAIT state:**
  - While dmem_busy = 1: pipe_stall = 1, pc_write = 0, ifid_write = 0.
  - exmem_branch_taken and lu are ignored while frozen. Their sources are frozen and are re-evaluated after exit.
  - When dmem_busy = 0: outputs follow the RUN rules in the same cycle; next state is RUN, or FLUSH_DONE if the branch fires.
- **FLUSH_DONE state:**
  - Lasts one cycle; outputs follow the RUN rules.
  - lu is suppressed, because ID/EX holds a bubble.
  - exmem_branch_taken is ignored (EX/MEM was flushed).
  - dmem_busy still takes the FSM to MEM_WAIT.
  - Next state: RUN unless dmem_busy = 1.
- All flush, write and stall outputs are combinational from state and inputs. The state and counters are registered.
- **Counters:**
  - stall_count increments on every cycle with pc_write = 0.
  - flush_count increments on each branch flush cycle.
  - Both saturate at all-ones.
  - cnt_clr = 1 zeroes both counters on the next edge; clear wins over increment in the same cycle.

## Timing
- Reset (reset = 0, asynchronous):
  - state = RUN, stall_count = 0, flush_count = 0
  - combinational outputs take RUN values: pc_write = 1, ifid_write = 1, flushes 0, pipe_stall 0, assuming idle inputs
- Release is synchronous to the first clk edge with reset = 1.
- Load-use costs exactly 1 stall cycle. Back-to-back dependent loads cost 1 cycle each.
- A taken branch costs 3 flushed slots and 0 stall cycles.
- A dmem wait of N busy cycles costs N stall cycles. There is no extra cycle on exit.
- Reset asserted mid-MEM_WAIT or mid-FLUSH_DONE returns to RUN immediately. Counters clear; there is no pending carry-over.

## Test plan
- idex_MemRead = 1, idex_rd = 5, ifid_rs2 = 5 for one cycle -> pc_write = 0, ifid_write = 0, idex_flush = 1 that cycle; stall_count = 1; state stays RUN.
- idex_MemRead = 1, idex_rd = 0, ifid_rs1 = 0 -> no stall, pc_write = 1, stall_count unchanged.
- exmem_branch_taken = 1 with lu also true -> three flushes asserted, pc_write = 1, state = FLUSH_DONE for 1 cycle then RUN, flush_count = 1.
- dmem_busy high for 4 cycles, with exmem_branch_taken = 1 throughout and beyond:
  - during the busy cycles: pipe_stall = 1, state = MEM_WAIT, stall_count = 4
  - in the cycle busy drops: the branch flush fires, then state = FLUSH_DONE
- Preload stall_count to all-ones via a long dmem_busy (use CNT_W = 4: 20 busy cycles) -> count holds at 15. Then cnt_clr = 1 during a stall cycle -> count = 0.
- Assert reset = 0 in the 2nd cycle of MEM_WAIT -> state = RUN and counters = 0 immediately, without a clock edge.
